// File: rtl/clkmux4_noglitch.sv
// Glitch-free 4:1 clock/strobe multiplexer: sources, select and enable are
// resynchronised to CLK_I and channels are swapped only while the output is low.
//
// state     | meaning
// ST_OFF    | output parked low, waiting for enable
// ST_ARM    | tracking select, waiting for the target source to be low
// ST_ACTIVE | output follows the current source
// ST_DRAIN  | switch requested, letting the current high phase finish
// ST_GUARD  | output held low while the guard counter runs down

module clkmux4_noglitch #(
   parameter int SYNC_STAGES  = 2,
   parameter int GUARD_CYCLES = 2
) (
   input  logic       CLK_I,
   input  logic       NRST_I,
   input  logic       DATA3_I,
   input  logic       DATA2_I,
   input  logic       DATA1_I,
   input  logic       DATA0_I,
   input  logic [1:0] SEL_I,
   input  logic       EN_I,
   output logic       DATA_O
);

   localparam int CW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_ARM,
      ST_ACTIVE,
      ST_DRAIN,
      ST_GUARD
   } state_t;

   // bit 6 enable, bits 5:4 select, bits 3:0 sources
   logic [6:0] raw;
   logic [6:0] sync_q [SYNC_STAGES];
   logic [3:0] s_d;
   logic [1:0] s_sel;
   logic       s_en;

   assign raw   = {EN_I, SEL_I, DATA3_I, DATA2_I, DATA1_I, DATA0_I};
   assign s_d   = sync_q[SYNC_STAGES-1][3:0];
   assign s_sel = sync_q[SYNC_STAGES-1][5:4];
   assign s_en  = sync_q[SYNC_STAGES-1][6];

   always_ff @(posedge CLK_I or negedge NRST_I) begin
      if (!NRST_I) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   state_t        state;
   logic [1:0]    cur;
   logic [1:0]    target;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK_I or negedge NRST_I) begin
      if (!NRST_I) begin
         state  <= ST_OFF;
         cur    <= 2'd0;
         target <= 2'd0;
         cnt    <= '0;
         DATA_O <= 1'b0;
      end else begin
         // DRAIN keeps following the source so a high phase is never truncated
         DATA_O <= ((state == ST_ACTIVE) || (state == ST_DRAIN)) && s_d[cur];
         case (state)
            ST_OFF: begin
               if (s_en) begin
                  target <= s_sel;
                  state  <= ST_ARM;
               end
            end
            ST_ARM: begin
               target <= s_sel;
               if (!s_en) begin
                  state <= ST_OFF;
               end else if (!s_d[target]) begin
                  cur   <= target;
                  state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (!s_en || (s_sel != cur)) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!s_d[cur]) begin
                  cnt   <= CW'(GUARD_CYCLES);
                  state <= ST_GUARD;
               end
            end
            ST_GUARD: begin
               if (cnt == '0) begin
                  if (s_en) begin
                     target <= s_sel;
                     state  <= ST_ARM;
                  end else begin
                     state <= ST_OFF;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= ST_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_clkmux4_noglitch.sv
// Directed bench for clkmux4_noglitch: sources toggle on falling CLK_I edges,
// a monitor measures DATA_O pulse widths, each task checks one scenario.

module tb_clkmux4_noglitch;

   logic       clk_i  = 1'b0;
   logic       nrst_i = 1'b1;
   logic [3:0] data   = 4'b0;
   logic [1:0] sel    = 2'd0;
   logic       en     = 1'b0;
   logic       data_o;

   clkmux4_noglitch #(.SYNC_STAGES(2), .GUARD_CYCLES(2)) dut (
      .CLK_I  (clk_i),
      .NRST_I (nrst_i),
      .DATA3_I(data[3]),
      .DATA2_I(data[2]),
      .DATA1_I(data[1]),
      .DATA0_I(data[0]),
      .SEL_I  (sel),
      .EN_I   (en),
      .DATA_O (data_o)
   );

   always #5 clk_i = ~clk_i;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0, run_len = 0, hi_w = 0, lo_w = 0;
   int   min_hi = 1000, min_lo = 1000;
   int   n_rise = 0, n_fall = 0, out_rise = 0;
   int   src_rise [4];
   int   hp [4];
   int   cnt [4];
   logic run [4];
   logic frc [4];
   logic prev_o = 1'b0;

   // source generator and output pulse monitor share one falling edge
   initial begin : gen_mon
      logic nv;
      forever begin
         @(negedge clk_i);
         cyc++;
         for (int n = 0; n < 4; n++) begin
            nv = data[n];
            if (run[n]) begin
               cnt[n]++;
               if (cnt[n] >= hp[n]) begin
                  nv     = ~data[n];
                  cnt[n] = 0;
               end
            end else begin
               nv = frc[n];
            end
            if (nv && !data[n]) src_rise[n] = cyc;
            data[n] = nv;
         end
         if (data_o !== prev_o) begin
            if (data_o === 1'b1) begin
               lo_w = run_len;
               if (lo_w < min_lo) min_lo = lo_w;
               n_rise++;
               out_rise = cyc;
            end else begin
               hi_w = run_len;
               if (hi_w < min_hi) min_hi = hi_w;
               n_fall++;
            end
            run_len = 1;
            prev_o  = data_o;
         end else begin
            run_len++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic wait_rise(input int budget, input string name);
      int start, k;
      start = n_rise;
      k = 0;
      while (n_rise == start && k < budget) begin
         step(1);
         k++;
      end
      checks++;
      if (n_rise == start) begin
         errors++;
         $display("FAIL %s: no DATA_O rise within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_fall(input int budget, input string name);
      int start, k;
      start = n_fall;
      k = 0;
      while (n_fall == start && k < budget) begin
         step(1);
         k++;
      end
      checks++;
      if (n_fall == start) begin
         errors++;
         $display("FAIL %s: no DATA_O fall within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      logic bad;
      bad = 1'b0;
      en  = 1'b1;
      sel = 2'd0;
      #1 nrst_i = 1'b0;
      repeat (5) begin
         step(1);
         if (data_o !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_low: DATA_O went high during reset, required 0");
      end
      nrst_i = 1'b1;
      step(10);
      cnt[0] = 0;
      run[0] = 1'b1;
      wait_rise(40, "reset_first_rise");
      checks++;
      if (out_rise - src_rise[0] !== 3) begin
         errors++;
         $display("FAIL reset_latency: got %0d cycles, required 3", out_rise - src_rise[0]);
      end
      wait_fall(40, "reset_first_fall");
      checks++;
      if (hi_w !== 7) begin
         errors++;
         $display("FAIL reset_first_high: width %0d, required 7", hi_w);
      end
      wait_fall(40, "reset_second_fall");
      checks++;
      if (lo_w !== 7) begin
         errors++;
         $display("FAIL reset_low_phase: width %0d, required 7", lo_w);
      end
      checks++;
      if (hi_w !== 7) begin
         errors++;
         $display("FAIL reset_second_high: width %0d, required 7", hi_w);
      end
   endtask

   task automatic test_switch();
      int exp_w [4];
      exp_w = '{70, 50, 30, 10};
      hp[0] = 70;
      for (int n = 0; n < 4; n++) begin
         cnt[n] = 0;
         run[n] = 1'b1;
      end
      min_hi = 1000;
      min_lo = 1000;
      for (int s = 1; s < 4; s++) begin
         sel = 2'(s);
         step(400);
         checks++;
         if (hi_w !== exp_w[s]) begin
            errors++;
            $display("FAIL switch_high_ch%0d: width %0d, required %0d", s, hi_w, exp_w[s]);
         end
         checks++;
         if (lo_w !== exp_w[s]) begin
            errors++;
            $display("FAIL switch_low_ch%0d: width %0d, required %0d", s, lo_w, exp_w[s]);
         end
      end
      checks++;
      if (min_hi !== 10) begin
         errors++;
         $display("FAIL switch_min_high: %0d, required 10", min_hi);
      end
      checks++;
      if (min_lo < 2) begin
         errors++;
         $display("FAIL switch_min_low: %0d, required >= 2", min_lo);
      end
   endtask

   task automatic test_disable();
      int snap;
      sel = 2'd0;
      step(300);
      wait_rise(200, "disable_rise");
      en = 1'b0;
      wait_fall(200, "disable_fall");
      checks++;
      if (hi_w !== 70) begin
         errors++;
         $display("FAIL disable_complete: width %0d, required 70", hi_w);
      end
      snap = n_rise;
      sel  = 2'd3;
      step(200);
      checks++;
      if (n_rise !== snap || data_o !== 1'b0) begin
         errors++;
         $display("FAIL disable_quiet: rises %0d out %b, required 0 rises out 0", n_rise - snap, data_o);
      end
      en = 1'b1;
      wait_rise(100, "resume_rise");
      wait_fall(100, "resume_fall");
      checks++;
      if (hi_w !== 10) begin
         errors++;
         $display("FAIL resume_width: width %0d, required 10", hi_w);
      end
   endtask

   task automatic test_bounce();
      sel = 2'd1;
      step(300);
      wait_rise(200, "bounce_rise");
      step(5);
      sel = 2'd2;
      step(2);
      sel = 2'd1;
      wait_fall(100, "bounce_drain_fall");
      checks++;
      if (hi_w !== 50) begin
         errors++;
         $display("FAIL bounce_drained_high: width %0d, required 50", hi_w);
      end
      wait_rise(150, "bounce_resume_rise");
      checks++;
      if (lo_w !== 50) begin
         errors++;
         $display("FAIL bounce_gap: width %0d, required 50", lo_w);
      end
      wait_fall(100, "bounce_resume_fall");
      checks++;
      if (hi_w !== 50) begin
         errors++;
         $display("FAIL bounce_next_high: width %0d, required 50", hi_w);
      end
   endtask

   task automatic test_stuck();
      int snap;
      run[2] = 1'b0;
      frc[2] = 1'b1;
      sel    = 2'd2;
      step(150);
      snap = n_rise;
      step(200);
      checks++;
      if (n_rise !== snap || data_o !== 1'b0) begin
         errors++;
         $display("FAIL stuck_parked: rises %0d out %b, required 0 rises out 0", n_rise - snap, data_o);
      end
      frc[2] = 1'b0;
      step(10);
      cnt[2] = 0;
      run[2] = 1'b1;
      wait_rise(100, "stuck_release_rise");
      checks++;
      if (out_rise - src_rise[2] !== 3) begin
         errors++;
         $display("FAIL stuck_latency: got %0d cycles, required 3", out_rise - src_rise[2]);
      end
      wait_fall(100, "stuck_release_fall");
      checks++;
      if (hi_w !== 30) begin
         errors++;
         $display("FAIL stuck_first_high: width %0d, required 30", hi_w);
      end
   endtask

   task automatic test_async_reset();
      sel = 2'd1;
      step(200);
      wait_rise(150, "areset_rise");
      step(5);
      en = 1'b0;
      step(4);
      checks++;
      if (data_o !== 1'b1) begin
         errors++;
         $display("FAIL areset_draining_high: out %b, required 1", data_o);
      end
      #1 nrst_i = 1'b0;
      #1;
      checks++;
      if (data_o !== 1'b0) begin
         errors++;
         $display("FAIL areset_immediate: out %b, required 0", data_o);
      end
      step(3);
      nrst_i = 1'b1;
      step(3);
   endtask

   initial begin
      hp = '{7, 50, 30, 10};
      for (int n = 0; n < 4; n++) begin
         cnt[n]      = 0;
         run[n]      = 1'b0;
         frc[n]      = 1'b0;
         src_rise[n] = 0;
      end
      test_reset();
      test_switch();
      test_disable();
      test_bounce();
      test_stuck();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
